multicycle_control: RTL and testbench

//  Main control FSM of the multi-cycle MIPS core. Sequences fetch/decode/execute/memory/writeback

---
 rtl/multicycle_control.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch/decode/execute/memory/writeback.
// Optional performance counters (cycle_count, instr_count) are enabled by defining MULTICYCLE_PERF_CNT_EN.
module multicycle_control #(
  parameter logic [2:0] ALUOP_ADD = 3'b010,
  parameter logic [2:0] ALUOP_SUB = 3'b110,
  parameter logic [2:0] ALUOP_OR  = 3'b001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        iord,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic [3:0]  state,
`ifdef MULTICYCLE_PERF_CNT_EN
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count,
`endif
  output logic        illegal_op
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;

  // Selects funct decode inside alu_control; not overridable.
  localparam logic [2:0] ALUOP_RTYPE = 3'b111;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    RTYPEEX = 4'd7,
    IMMEX   = 4'd8,
    ALUWB   = 4'd9,
    BEQEX   = 4'd10,
    JEX     = 4'd11
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   is_rtype;
  logic   illegal_set;

  // State register, R-type flag and sticky illegal-opcode flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      is_rtype   <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) is_rtype <= (opcode == OP_RTYPE);
      if (illegal_set) illegal_op <= 1'b1;
    end
  end

  // Next-state and Moore outputs; states 12-15 fall through to defaults and recover to FETCH.
  always_comb begin
    state_d     = state_q;
    illegal_set = 1'b0;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = ALUOP_ADD;
    pc_src      = 2'b00;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:       state_d = RTYPEEX;
          OP_LW, OP_SW:   state_d = MEMADR;
          OP_BEQ:         state_d = BEQEX;
          OP_ADDI, OP_ORI: state_d = IMMEX;
          OP_J:           state_d = JEX;
          default: begin
            illegal_set = 1'b1;
            state_d     = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_RTYPE;
        state_d   = ALUWB;
      end
      IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = is_rtype;
        state_d   = FETCH;
      end
      BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 2'b01;
        pc_write  = zero;
        state_d   = FETCH;
      end
      JEX: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign state = STATE_W'(state_q);

`ifdef MULTICYCLE_PERF_CNT_EN
  // Active-cycle and retired-instruction counters; both wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= 32'd0;
      instr_count <= 32'd0;
    end else begin
      if (state_q != IDLE) cycle_count <= cycle_count + 32'd1;
      if (state_d == FETCH && state_q != IDLE && state_q != FETCH)
        instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control: walks each instruction class and checks
// state sequence and control strobes against hand-derived values.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, ir_write, mem_read, mem_write, iord;
  logic        reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_op;
  logic [3:0]  state;
`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycle_count, instr_count;
`endif

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned ir_pulses;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .iord       (iord),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .state      (state),
`ifdef MULTICYCLE_PERF_CNT_EN
    .cycle_count(cycle_count),
    .instr_count(instr_count),
`endif
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    #1;
    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      check("rst_state", 32'(state), 32'd0);
      check("rst_strobes", 32'({pc_write, ir_write, mem_read, mem_write, reg_write}), 32'd0);
      check("rst_illegal", 32'(illegal_op), 32'd0);
      tick();
    end
    check("rst_aluop", 32'(alu_op), 32'd2);
    reset = 1'b0;
    #1;
    check("idle", 32'(state), 32'd0);
    tick();
    check("fetch", 32'(state), 32'd1);
    check("fetch_memrd", 32'(mem_read), 32'd1);
    check("fetch_srcb", 32'(alu_src_b), 32'd1);

    // LW with mem_ready always 1
    opcode = 6'b100011; mem_ready = 1'b1; #1;
    check("fetch_irw", 32'({ir_write, pc_write}), 32'd3);
    tick(); check("lw_decode", 32'(state), 32'd2);
    check("lw_dec_srcb", 32'(alu_src_b), 32'd3);
    check("lw_dec_rw", 32'(reg_write), 32'd0);
    tick(); check("lw_memadr", 32'(state), 32'd3);
    check("lw_adr_src", 32'({alu_src_a, alu_src_b}), 32'b110);
    tick(); check("lw_memrd", 32'(state), 32'd4);
    check("lw_rd_strb", 32'({mem_read, iord, mem_write}), 32'b110);
    tick(); check("lw_memwb", 32'(state), 32'd5);
    check("lw_wb_strb", 32'({reg_write, mem_to_reg, reg_dst}), 32'b110);
    tick(); check("lw_refetch", 32'(state), 32'd1);
    check("lw_rw_off", 32'({reg_write, mem_to_reg}), 32'd0);

    // R-type with FETCH stalled 3 cycles
    opcode = 6'b000000;
    ir_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      check("rt_fetch_hold", 32'(state), 32'd1);
      if (ir_write) ir_pulses++;
      tick();
    end
    check("rt_ir_pulses", 32'(ir_pulses), 32'd1);
    check("rt_decode", 32'(state), 32'd2);
    tick(); check("rt_ex", 32'(state), 32'd7);
    check("rt_aluop", 32'(alu_op), 32'd7);
    check("rt_src", 32'({alu_src_a, alu_src_b}), 32'b100);
    tick(); check("rt_aluwb", 32'(state), 32'd9);
    check("rt_wb", 32'({reg_write, reg_dst, mem_to_reg}), 32'b110);
    tick(); check("rt_refetch", 32'(state), 32'd1);

    // BEQ, zero both ways
    opcode = 6'b000100;
    tick(); tick();
    check("beq_ex", 32'(state), 32'd10);
    zero = 1'b1; #1;
    check("beq_taken", 32'({pc_write, pc_src}), 32'b101);
    check("beq_aluop", 32'(alu_op), 32'd6);
    zero = 1'b0; #1;
    check("beq_not_taken", 32'(pc_write), 32'd0);
    tick(); check("beq_refetch", 32'(state), 32'd1);

    // Illegal opcode, then ADDI / ORI / J with the sticky flag held
    opcode = 6'b111111;
    tick(); check("ill_decode", 32'(state), 32'd2);
    check("ill_not_yet", 32'(illegal_op), 32'd0);
    tick(); check("ill_refetch", 32'(state), 32'd1);
    check("ill_set", 32'(illegal_op), 32'd1);
    opcode = 6'b001000;
    tick(); tick();
    check("addi_ex", 32'(state), 32'd8);
    check("addi_aluop", 32'(alu_op), 32'd2);
    check("addi_srcb", 32'(alu_src_b), 32'd2);
    tick(); check("addi_wb", 32'({4'(state), reg_write, reg_dst}), 32'b1001_10);
    tick(); check("addi_refetch", 32'(state), 32'd1);
    check("ill_sticky", 32'(illegal_op), 32'd1);
    opcode = 6'b001101;
    tick(); tick();
    check("ori_aluop", 32'({4'(state), alu_op}), 32'b1000_001);
    tick(); tick();
    opcode = 6'b000010;
    tick(); tick();
    check("j_ex", 32'(state), 32'd11);
    check("j_pc", 32'({pc_write, pc_src}), 32'b110);
    tick(); check("j_refetch", 32'(state), 32'd1);
    reset = 1'b1; #1;
    check("ill_cleared", 32'(illegal_op), 32'd0);
    tick(); reset = 1'b0; #1;
    tick(); check("post_rst_fetch", 32'(state), 32'd1);

    // SW stalled in MEMWR, then reset mid-access
    opcode = 6'b101011; mem_ready = 1'b1;
    tick(); tick();
    check("sw_memadr", 32'(state), 32'd3);
    mem_ready = 1'b0;
    tick(); check("sw_memwr", 32'(state), 32'd6);
    check("sw_strb", 32'({mem_write, mem_read, iord}), 32'b101);
    tick(); check("sw_hold", 32'(state), 32'd6);
    reset = 1'b1; #1;
    check("sw_rst_mw", 32'(mem_write), 32'd0);
    check("sw_rst_state", 32'(state), 32'd0);
    tick(); reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
